// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl: decode-to-execute issue control with load scoreboard and branch serialisation
module exec_issue_ctrl #(
  parameter int MAX_LOADS = 4,
  parameter int STALL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_dec_valid,
  output logic               o_dec_ready,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic               i_use_rs1,
  input  logic               i_use_rs2,
  input  logic               i_wr_rd,
  input  logic               i_is_load,
  input  logic               i_is_ctrl,
  input  logic [63:0]        i_Single_Instruction,
  output logic               o_ex_valid,
  output logic [4:0]         o_ex_rd,
  output logic [4:0]         o_ex_rs1,
  output logic [4:0]         o_ex_rs2,
  output logic [63:0]        o_ex_inst,
  input  logic               i_ld_done,
  input  logic [4:0]         i_ld_done_rd,
  input  logic               i_br_resolved,
  input  logic               i_br_taken,
  output logic               o_flush,
  output logic [31:0]        o_pending,
  output logic [STALL_W-1:0] o_stall_cycles,
  output logic               o_err
);
  localparam logic [1:0] RUN = 2'd0, BR_WAIT = 2'd1, FLUSH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] pend_d;
  logic [STALL_W-1:0] stall_d;
  logic err_d, hazard, issue, ld_inc;
  assign hazard = (i_use_rs1 & |i_rs1 & o_pending[i_rs1])
                | (i_use_rs2 & |i_rs2 & o_pending[i_rs2])
                | (i_wr_rd & |i_rd & o_pending[i_rd]);
  assign o_dec_ready = (state_q == RUN) & !hazard & !(i_is_load & ld_cnt_q == 4'(MAX_LOADS));
  assign issue = i_dec_valid & o_dec_ready;
  assign ld_inc = issue & i_is_load;
  assign o_flush = state_q == FLUSH;
  always_comb begin
    pend_d = o_pending;
    if (ld_inc && i_rd != 5'd0) pend_d[i_rd] = 1'b1;
    if (i_ld_done) pend_d[i_ld_done_rd] = 1'b0;
    pend_d[0] = 1'b0;
    ld_cnt_d = ld_cnt_q;
    if (ld_inc && !i_ld_done) ld_cnt_d = ld_cnt_q + 4'd1;
    else if (!ld_inc && i_ld_done && ld_cnt_q != 4'd0) ld_cnt_d = ld_cnt_q - 4'd1;
    err_d = o_err | (i_ld_done & ld_cnt_q == 4'd0) | (i_br_resolved & state_q != BR_WAIT);
    stall_d = (i_dec_valid & !o_dec_ready & ~&o_stall_cycles) ? o_stall_cycles + 1'b1 : o_stall_cycles;
    state_d = state_q;
    if (state_q == RUN && issue && i_is_ctrl) state_d = BR_WAIT;
    else if (state_q == BR_WAIT && i_br_resolved) state_d = i_br_taken ? FLUSH : RUN;
    else if (state_q == FLUSH) state_d = RUN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      ld_cnt_q <= '0;
      o_pending <= '0;
      o_stall_cycles <= '0;
      o_err <= 1'b0;
      o_ex_valid <= 1'b0;
      o_ex_rd <= '0;
      o_ex_rs1 <= '0;
      o_ex_rs2 <= '0;
      o_ex_inst <= '0;
    end else begin
      state_q <= state_d;
      ld_cnt_q <= ld_cnt_d;
      o_pending <= pend_d;
      o_stall_cycles <= stall_d;
      o_err <= err_d;
      o_ex_valid <= issue;
      if (issue) begin
        o_ex_rd <= i_rd;
        o_ex_rs1 <= i_rs1;
        o_ex_rs2 <= i_rs2;
        o_ex_inst <= i_Single_Instruction;
      end
    end
  end
endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb_exec_issue_ctrl: directed vectors for exec_issue_ctrl with hand-computed expectations
module tb_exec_issue_ctrl;
  logic clk = 0, rst_n = 0;
  logic dec_valid, dec_ready, use_rs1, use_rs2, wr_rd, is_load, is_ctrl;
  logic [4:0] rd, rs1, rs2, ex_rd, ex_rs1, ex_rs2, ld_done_rd;
  logic [63:0] inst, ex_inst;
  logic ex_valid, ld_done, br_resolved, br_taken, flush, err;
  logic [31:0] pending;
  logic [15:0] stall;
  int n_chk = 0, n_pass = 0;
  localparam logic [63:0] ADD = 64'h1 << 10, LW = 64'h1 << 20, BEQ = 64'h1 << 30, BNE = 64'h1 << 31;

  exec_issue_ctrl #(.MAX_LOADS(4), .STALL_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
    .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_use_rs1(use_rs1), .i_use_rs2(use_rs2),
    .i_wr_rd(wr_rd), .i_is_load(is_load), .i_is_ctrl(is_ctrl), .i_Single_Instruction(inst),
    .o_ex_valid(ex_valid), .o_ex_rd(ex_rd), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_inst(ex_inst),
    .i_ld_done(ld_done), .i_ld_done_rd(ld_done_rd), .i_br_resolved(br_resolved), .i_br_taken(br_taken),
    .o_flush(flush), .o_pending(pending), .o_stall_cycles(stall), .o_err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; rd = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; wr_rd = 0;
    is_load = 0; is_ctrl = 0; inst = 0; ld_done = 0; ld_done_rd = 0; br_resolved = 0; br_taken = 0;
  endtask

  task automatic add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    idle();
    dec_valid = 1; rd = d; rs1 = a; rs2 = b; use_rs1 = 1; use_rs2 = 1; wr_rd = 1; inst = ADD;
  endtask

  task automatic lw(input logic [4:0] d);
    idle();
    dec_valid = 1; rd = d; wr_rd = 1; is_load = 1; inst = LW;
  endtask

  task automatic br(input logic [63:0] code);
    idle();
    dec_valid = 1; rs1 = 5'd1; rs2 = 5'd2; use_rs1 = 1; use_rs2 = 1; is_ctrl = 1; inst = code;
  endtask

  initial begin
    idle();
    #23;
    chk("rst_ex_valid", 64'(ex_valid), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_flush", 64'(flush), 0);
    rst_n = 1;
    step();
    // basic issue
    add(5, 1, 2);
    #1 chk("add_ready", 64'(dec_ready), 1);
    step();
    chk("add_ex_valid", 64'(ex_valid), 1);
    chk("add_ex_rd", 64'(ex_rd), 5);
    chk("add_ex_rs2", 64'(ex_rs2), 2);
    chk("add_ex_inst", ex_inst, ADD);
    idle();
    step();
    chk("add_ex_pulse", 64'(ex_valid), 0);
    chk("add_ex_hold", 64'(ex_rd), 5);
    // load-use stall
    lw(3);
    step();
    chk("lw_pending", 64'(pending), 32'h8);
    add(7, 3, 0);
    #1 chk("raw_ready", 64'(dec_ready), 0);
    step();
    step();
    chk("raw_stall2", 64'(stall), 2);
    ld_done = 1; ld_done_rd = 3;
    #1 chk("raw_no_bypass", 64'(dec_ready), 0);
    step();
    ld_done = 0;
    chk("raw_stall3", 64'(stall), 3);
    chk("raw_cleared", 64'(pending), 0);
    #1 chk("raw_ready_after", 64'(dec_ready), 1);
    step();
    chk("raw_issue", 64'(ex_valid), 1);
    chk("raw_issue_rd", 64'(ex_rd), 7);
    // load limit
    for (int i = 1; i <= 4; i++) begin
      lw(5'(i));
      step();
    end
    chk("four_pending", 64'(pending), 32'h1E);
    lw(6);
    #1 chk("full_ready", 64'(dec_ready), 0);
    step();
    ld_done = 1; ld_done_rd = 1;
    step();
    ld_done = 0;
    #1 chk("full_ready_after", 64'(dec_ready), 1);
    step();
    chk("fifth_rd", 64'(ex_rd), 6);
    chk("fifth_pending", 64'(pending), 32'h5C);
    lw(8);
    #1 chk("cnt_is_4", 64'(dec_ready), 0);
    idle();
    chk("full_stall", 64'(stall), 5);
    for (int i = 0; i < 4; i++) begin
      ld_done = 1; ld_done_rd = (i == 3) ? 5'd6 : 5'(i + 2);
      step();
    end
    ld_done = 0;
    chk("drained", 64'(pending), 0);
    chk("no_err_yet", 64'(err), 0);
    // taken branch with flush
    br(BEQ);
    #1 chk("beq_ready", 64'(dec_ready), 1);
    step();
    chk("beq_issue", 64'(ex_valid), 1);
    add(9, 1, 2);
    #1 chk("brwait_ready", 64'(dec_ready), 0);
    step();
    br_resolved = 1; br_taken = 1;
    step();
    br_resolved = 0; br_taken = 0;
    chk("flush_on", 64'(flush), 1);
    #1 chk("flush_ready", 64'(dec_ready), 0);
    step();
    chk("flush_off", 64'(flush), 0);
    #1 chk("post_flush_ready", 64'(dec_ready), 1);
    step();
    chk("post_flush_issue", 64'(ex_rd), 9);
    chk("br_stall", 64'(stall), 8);
    // not-taken branch, spurious resolve, x0 load
    br(BNE);
    step();
    idle();
    br_resolved = 1; br_taken = 0;
    step();
    br_resolved = 0;
    chk("nt_no_flush", 64'(flush), 0);
    #1 chk("nt_run", 64'(dec_ready), 1);
    chk("nt_err", 64'(err), 0);
    br_resolved = 1;
    step();
    br_resolved = 0;
    chk("spurious_err", 64'(err), 1);
    step();
    chk("err_sticky", 64'(err), 1);
    lw(0);
    step();
    chk("x0_pending", 64'(pending), 0);
    add(0, 0, 0);
    #1 chk("x0_no_stall", 64'(dec_ready), 1);
    step();
    chk("x0_issue", 64'(ex_valid), 1);
    // async reset mid-operation
    lw(9);
    step();
    lw(10);
    step();
    br(BEQ);
    step();
    chk("pre_rst_pending", 64'(pending), 32'h600);
    add(11, 1, 2);
    #1 chk("pre_rst_brwait", 64'(dec_ready), 0);
    #2 rst_n = 0;
    #1;
    chk("arst_pending", 64'(pending), 0);
    chk("arst_ex_valid", 64'(ex_valid), 0);
    chk("arst_err", 64'(err), 0);
    chk("arst_stall", 64'(stall), 0);
    chk("arst_run", 64'(dec_ready), 1);
    idle();
    step();
    rst_n = 1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
